// File: rtl/emif_test_pkg.sv
// Shared definitions for the EMIF burst test: FSM encoding, default burst shape
// and the beat pattern used by both the driver and the read-back checker.
package emif_test_pkg;

  localparam int BURSTLEN_DEF = 144;
  localparam int PAT_STEP_DEF = 100;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_RD_CMD  = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Beat k (0-based) carries step*(k+1); callers zero-extend or truncate to DATA_W.
  function automatic logic [63:0] pattern(input logic [31:0] k, input logic [31:0] step);
    return {32'd0, step} * {32'd0, k + 32'd1};
  endfunction

endpackage

// File: rtl/emif_pattern_gen.sv
// Maps a beat index to its DATA_W-wide test pattern; purely combinational.
module emif_pattern_gen
  import emif_test_pkg::*;
#(
  parameter int DATA_W   = 320,
  parameter int BC_W     = 8,
  parameter int PAT_STEP = PAT_STEP_DEF
) (
  input  logic [BC_W-1:0]   beat,
  output logic [DATA_W-1:0] data
);

  assign data = DATA_W'(pattern(32'(beat), 32'(PAT_STEP)));

endmodule

// File: rtl/emif_burst_driver.sv
// Avalon-MM master for the EMIF test: writes one pattern burst, reads it back
// and counts mismatching beats, with an idle timeout on the read return.
module emif_burst_driver
  import emif_test_pkg::*;
#(
  parameter int DATA_W    = 320,
  parameter int ADDR_W    = 27,
  parameter int BC_W      = 8,
  parameter int BURSTLEN  = BURSTLEN_DEF,
  parameter int BASE_ADDR = 0,
  parameter int PAT_STEP  = PAT_STEP_DEF,
  parameter int TIMEOUT   = 4095
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                amm_ready,
  output logic                amm_write,
  output logic                amm_read,
  output logic [ADDR_W-1:0]   amm_address,
  output logic [BC_W-1:0]     amm_burstcount,
  output logic [DATA_W-1:0]   amm_wrdata,
  output logic [DATA_W/8-1:0] amm_byteenable,
  input  logic [DATA_W-1:0]   amm_rddata,
  input  logic                amm_rddatavalid,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [15:0]         err_count,
  output logic [BC_W-1:0]     first_err_beat
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BURSTLEN - 1);

  logic [2:0]        state_q, state_d;
  logic              start_q;
  logic [BC_W-1:0]   beat_q, beat_d;
  logic [BC_W-1:0]   rbeat_q, rbeat_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [15:0]       err_q, err_d;
  logic [BC_W-1:0]   first_q, first_d;
  logic              timeout_q, timeout_d;
  logic              start_edge;
  logic [DATA_W-1:0] wr_pattern;
  logic [DATA_W-1:0] cmp_pattern;

  emif_pattern_gen #(.DATA_W(DATA_W), .BC_W(BC_W), .PAT_STEP(PAT_STEP)) u_wr_pat (
    .beat (beat_q),
    .data (wr_pattern)
  );

  emif_pattern_gen #(.DATA_W(DATA_W), .BC_W(BC_W), .PAT_STEP(PAT_STEP)) u_cmp_pat (
    .beat (rbeat_q),
    .data (cmp_pattern)
  );

  assign start_edge = start & ~start_q;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    rbeat_d   = rbeat_q;
    idle_d    = idle_q;
    err_d     = err_q;
    first_d   = first_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          state_d   = ST_WR;
          beat_d    = '0;
          rbeat_d   = '0;
          idle_d    = '0;
          err_d     = '0;
          first_d   = '0;
          timeout_d = 1'b0;
        end
      end
      ST_WR: begin
        if (amm_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_RD_CMD;
        end
      end
      ST_RD_CMD: begin
        if (amm_ready) begin
          state_d = ST_RD_WAIT;
          idle_d  = '0;
        end
      end
      ST_RD_WAIT: begin
        if (amm_rddatavalid) begin
          idle_d  = '0;
          rbeat_d = rbeat_q + 1'b1;
          if (amm_rddata != cmp_pattern) begin
            // A zero count marks "no mismatch yet", so only the first one is latched.
            if (err_q == 16'd0) first_d = rbeat_q;
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          end
          if (rbeat_q == LAST_BEAT) state_d = ST_DONE;
        end else begin
          idle_d = idle_q + 1'b1;
          if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      beat_q    <= '0;
      rbeat_q   <= '0;
      idle_q    <= '0;
      err_q     <= '0;
      first_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      beat_q    <= beat_d;
      rbeat_q   <= rbeat_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      first_q   <= first_d;
      timeout_q <= timeout_d;
    end
  end

  assign amm_write      = (state_q == ST_WR);
  assign amm_read       = (state_q == ST_RD_CMD);
  assign amm_address    = (amm_write | amm_read) ? ADDR_W'(BASE_ADDR) : '0;
  assign amm_burstcount = (amm_write | amm_read) ? BC_W'(BURSTLEN) : '0;
  assign amm_wrdata     = amm_write ? wr_pattern : '0;
  assign amm_byteenable = '1;

  assign busy           = amm_write | amm_read | (state_q == ST_RD_WAIT);
  assign done           = (state_q == ST_DONE);
  assign pass           = done & (err_q == 16'd0) & ~timeout_q;
  assign timeout        = timeout_q;
  assign err_count      = err_q;
  assign first_err_beat = first_q;

endmodule
